// File: rtl/adder_acc_pipe.sv
// Registered adder/accumulator with add/sub/acc/load modes, optional saturation,
// carry/borrow flag and a saturating accumulate counter behind valid/ready.
module adder_acc_pipe #(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic [CNT_W-1:0] acc_cnt
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  op_e              op;
  logic             is_add;
  logic             is_sub;
  logic             is_acc;
  logic             accept;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] res;
  logic             carry_raw;

  // The result register doubles as the accumulator: both only change on accept.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op       = op_e'(mode);
  assign is_add   = (op == OP_ADD);
  assign is_sub   = (op == OP_SUB);
  assign is_acc   = (op == OP_ACC);
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum_w = '0;
    unique case (1'b1)
      is_add:  sum_w = {1'b0, in1} + {1'b0, in2};
      is_sub:  sum_w = {1'b0, in1} - {1'b0, in2};
      is_acc:  sum_w = {1'b0, acc_q} + {1'b0, in1};
      default: sum_w = {1'b0, in1};
    endcase
  end

  // Top bit is carry for add/acc, borrow for sub, always 0 for load.
  assign carry_raw = sum_w[WIDTH];

  always_comb begin
    res = sum_w[WIDTH-1:0];
    if (SAT && carry_raw) begin
      res = is_sub ? '0 : '1;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (accept) begin
      valid_d = 1'b1;
      acc_d   = res;
      carry_d = carry_raw;
      if (is_acc) begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out       = acc_q;
  assign carry     = carry_q;
  assign acc_cnt   = cnt_q;

endmodule

// File: tb/tb_adder_acc_pipe.sv
// Directed bench for adder_acc_pipe: three instances (wrap, saturate, 2-bit counter)
// checked every cycle against an arithmetic model plus literal expectations.
module tb_adder_acc_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic        out_ready = 1'b1;

  logic        r0, r1, r2;
  logic        v0, v1, v2;
  logic [15:0] o0, o1, o2;
  logic        c0, c1, c2;
  logic [7:0]  n0, n1;
  logic [1:0]  n2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  adder_acc_pipe #(.WIDTH(16), .SAT(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0),
    .mode(mode), .in1(in1), .in2(in2), .out_valid(v0),
    .out_ready(out_ready), .out(o0), .carry(c0), .acc_cnt(n0));

  adder_acc_pipe #(.WIDTH(16), .SAT(1'b1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
    .mode(mode), .in1(in1), .in2(in2), .out_valid(v1),
    .out_ready(out_ready), .out(o1), .carry(c1), .acc_cnt(n1));

  adder_acc_pipe #(.WIDTH(16), .SAT(1'b0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2),
    .mode(mode), .in1(in1), .in2(in2), .out_valid(v2),
    .out_ready(out_ready), .out(o2), .carry(c2), .acc_cnt(n2));

  // Model: plain integer arithmetic, returns {carry, result}.
  function automatic logic [16:0] f_op(input logic [1:0] md, input bit sat,
                                       input logic [15:0] acc,
                                       input logic [15:0] a,
                                       input logic [15:0] b);
    int s;
    bit c;
    case (md)
      2'd0:    s = int'(a) + int'(b);
      2'd1:    s = int'(a) - int'(b);
      2'd2:    s = int'(acc) + int'(a);
      default: s = int'(a);
    endcase
    c = (s > 65535) || (s < 0);
    if (c && sat) s = (s < 0) ? 0 : 65535;
    return {c, s[15:0]};
  endfunction

  logic        m_valid;
  logic [15:0] m_out[3];
  logic        m_car[3];
  int          m_cnt[3];
  logic [16:0] m_nx[3];
  int          cmax[3] = '{255, 255, 3};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      m_nx[i] = f_op(mode, i == 1, m_out[i], in1, in2);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_out[i] <= '0;
        m_car[i] <= 1'b0;
        m_cnt[i] <= 0;
      end
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        m_out[i] <= m_nx[i][15:0];
        m_car[i] <= m_nx[i][16];
        if (mode == 2'd2)
          m_cnt[i] <= (m_cnt[i] == cmax[i]) ? m_cnt[i] : m_cnt[i] + 1;
        else
          m_cnt[i] <= 0;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic r, input logic v,
                          input logic [15:0] o, input logic c,
                          input int n);
    chk($sformatf("u%0d.in_ready", i), int'(r), int'(!m_valid || out_ready));
    chk($sformatf("u%0d.out_valid", i), int'(v), int'(m_valid));
    chk($sformatf("u%0d.out", i), int'(o), int'(m_out[i]));
    chk($sformatf("u%0d.carry", i), int'(c), int'(m_car[i]));
    chk($sformatf("u%0d.acc_cnt", i), n, m_cnt[i]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, r0, v0, o0, c0, int'(n0));
    cmp_inst(1, r1, v1, o1, c1, int'(n1));
    cmp_inst(2, r2, v2, o2, c2, int'(n2));
  end

  task automatic send(input logic [1:0] m, input logic [15:0] a,
                      input logic [15:0] b);
    in_valid = 1'b1;
    mode = m;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a pending request
    in_valid = 1'b1;
    mode = 2'd0;
    in1 = 16'h0001;
    in2 = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", int'(v0), 0);
    chk("rst.out", int'(o0), 0);
    chk("rst.carry", int'(c0), 0);
    chk("rst.acc_cnt", int'(n0), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_ready", int'(r0), 1);
    chk("rst.no_capture", int'(v0), 0);

    send(2'd0, 16'h1234, 16'h0F0F);
    chk("add.out", int'(o0), 'h2143);
    chk("add.carry", int'(c0), 0);
    send(2'd0, 16'hFFFF, 16'h0002);
    chk("addc.out", int'(o0), 'h0001);
    chk("addc.carry", int'(c0), 1);
    chk("addsat.out", int'(o1), 'hFFFF);
    chk("addsat.carry", int'(c1), 1);
    send(2'd1, 16'h0005, 16'h0007);
    chk("subb.out", int'(o0), 'hFFFE);
    chk("subb.carry", int'(c0), 1);
    chk("subsat.out", int'(o1), 'h0000);
    send(2'd1, 16'h0010, 16'h0003);
    chk("sub.out", int'(o0), 'h000D);
    chk("sub.carry", int'(c0), 0);

    send(2'd3, 16'h0100, 16'h0000);
    chk("load.out", int'(o0), 'h0100);
    chk("load.cnt", int'(n0), 0);
    for (int k = 1; k <= 3; k++) begin
      send(2'd2, 16'h0010, 16'h0000);
      chk("acc.out", int'(o0), 'h0100 + 'h10 * k);
      chk("acc.cnt", int'(n0), k);
    end
    send(2'd0, 16'h0001, 16'h0001);
    chk("add.cnt_clr", int'(n0), 0);

    send(2'd3, 16'h0000, 16'h0000);
    repeat (5) send(2'd2, 16'h0001, 16'h0000);
    chk("cnt2.sat", int'(n2), 3);
    chk("cnt8.cnt", int'(n0), 5);
    chk("cnt8.out", int'(o0), 5);
    idle();

    // Backpressure
    out_ready = 1'b0;
    send(2'd0, 16'h0007, 16'h0008);
    chk("bp.first", int'(o0), 'h000F);
    mode = 2'd0;
    in1 = 16'h0001;
    in2 = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      chk("bp.in_ready", int'(r0), 0);
      chk("bp.hold", int'(o0), 'h000F);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", int'(r0), 1);
    @(posedge clk);
    #1;
    chk("bp.next", int'(o0), 'h0002);
    for (int k = 1; k <= 4; k++) begin
      send(2'd2, 16'h0001, 16'h0000);
      chk("stream.out", int'(o0), 2 + k);
      chk("stream.vld", int'(v0), 1);
    end
    idle();

    // Reset mid-accumulate
    send(2'd3, 16'h0000, 16'h0000);
    send(2'd2, 16'h0007, 16'h0000);
    send(2'd2, 16'h0007, 16'h0000);
    chk("mid.pre", int'(o0), 'h000E);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid.out_valid", int'(v0), 0);
    chk("mid.out", int'(o0), 0);
    chk("mid.acc_cnt", int'(n0), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'd2, 16'h0005, 16'h0000);
    chk("mid.acc", int'(o0), 'h0005);
    chk("mid.cnt", int'(n0), 1);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
